// File: rtl/turn_controller_if.sv
// Bomb-side link of the turn controller: launch request, aim and launch origin
// out to the projectile block, detonation status back.
interface turn_controller_if;
   logic       launch;
   logic [9:0] launchX;
   logic [9:0] launchY;
   logic [3:0] angle;
   logic [2:0] power;
   logic       bomb_done;

   // launch is a level held for exactly one frame; the bomb samples it on its
   // own frame tick. bomb_done is a level: 1 = idle/exploded, 0 = in flight.
   modport master (
      output launch,
      output launchX,
      output launchY,
      output angle,
      output power,
      input  bomb_done
   );

   modport slave (
      input  launch,
      input  launchX,
      input  launchY,
      input  angle,
      input  power,
      output bomb_done
   );
endinterface

// File: rtl/turn_controller.sv
// Two-player artillery turn sequencer: aim with auto-repeat, one-frame launch,
// flight wait with timeout, settle delay, then hand the turn over.
module turn_controller #(
   parameter int REPEAT_FRAMES  = 8,
   parameter int SETTLE_FRAMES  = 30,
   parameter int FLIGHT_TIMEOUT = 255,
   parameter int P0_ANGLE_INIT  = 2,
   parameter int P1_ANGLE_INIT  = 6,
   parameter int POWER_INIT     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_clk,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_fire,
   input  logic       pause,
   input  logic [9:0] p0_x,
   input  logic [9:0] p0_y,
   input  logic [9:0] p1_x,
   input  logic [9:0] p1_y,
   turn_controller_if.master bomb,
   output logic       player,
   output logic [2:0] state,
   output logic [7:0] turn_count
);

   localparam int RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
   localparam int FW = $clog2(FLIGHT_TIMEOUT + 1);
   localparam int SW = $clog2(SETTLE_FRAMES + 1);

   localparam logic [3:0] ANGLE_MAX = 4'd8;
   localparam logic [2:0] POWER_MAX = 3'd7;

   typedef enum logic [2:0] {
      S_AIM    = 3'd0,
      S_LAUNCH = 3'd1,
      S_FLIGHT = 3'd2,
      S_SETTLE = 3'd3,
      S_SWITCH = 3'd4
   } state_t;

   // frame strobe synchronizer and rising-edge detector
   logic [2:0] fsync_q;
   logic       tick_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsync_q <= 3'b000;
         tick_q  <= 1'b0;
      end else begin
         fsync_q <= {fsync_q[1:0], frame_clk};
         tick_q  <= fsync_q[1] & ~fsync_q[2];
      end
   end

   state_t        state_q, state_d;
   logic          player_q, player_d;
   logic [3:0]    ang0_q, ang0_d, ang1_q, ang1_d;
   logic [2:0]    pow0_q, pow0_d, pow1_q, pow1_d;
   logic [7:0]    tc_q, tc_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic          armed_q, armed_d;
   logic          fire_prev_q, fire_prev_d;
   logic          a_held_q, a_held_d, p_held_q, p_held_d;
   logic [RW-1:0] a_cnt_q, a_cnt_d, p_cnt_q, p_cnt_d;
   logic [9:0]    lx_q, lx_d, ly_q, ly_d;
   logic          launch_q, launch_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_AIM;
         player_q    <= 1'b0;
         ang0_q      <= 4'(P0_ANGLE_INIT);
         ang1_q      <= 4'(P1_ANGLE_INIT);
         pow0_q      <= 3'(POWER_INIT);
         pow1_q      <= 3'(POWER_INIT);
         tc_q        <= 8'd0;
         fcnt_q      <= '0;
         scnt_q      <= '0;
         armed_q     <= 1'b0;
         fire_prev_q <= 1'b1;
         a_held_q    <= 1'b0;
         a_cnt_q     <= '0;
         p_held_q    <= 1'b0;
         p_cnt_q     <= '0;
         lx_q        <= 10'd0;
         ly_q        <= 10'd0;
         launch_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         player_q    <= player_d;
         ang0_q      <= ang0_d;
         ang1_q      <= ang1_d;
         pow0_q      <= pow0_d;
         pow1_q      <= pow1_d;
         tc_q        <= tc_d;
         fcnt_q      <= fcnt_d;
         scnt_q      <= scnt_d;
         armed_q     <= armed_d;
         fire_prev_q <= fire_prev_d;
         a_held_q    <= a_held_d;
         a_cnt_q     <= a_cnt_d;
         p_held_q    <= p_held_d;
         p_cnt_q     <= p_cnt_d;
         lx_q        <= lx_d;
         ly_q        <= ly_d;
         launch_q    <= launch_d;
      end
   end

   logic          a_step, p_step;
   logic [3:0]    ang_cur, ang_new;
   logic [2:0]    pow_cur, pow_new;
   logic [FW-1:0] fcnt_inc;
   logic [SW-1:0] scnt_inc;

   always_comb begin
      state_d     = state_q;
      player_d    = player_q;
      ang0_d      = ang0_q;
      ang1_d      = ang1_q;
      pow0_d      = pow0_q;
      pow1_d      = pow1_q;
      tc_d        = tc_q;
      fcnt_d      = fcnt_q;
      scnt_d      = scnt_q;
      armed_d     = armed_q;
      fire_prev_d = fire_prev_q;
      a_held_d    = a_held_q;
      a_cnt_d     = a_cnt_q;
      p_held_d    = p_held_q;
      p_cnt_d     = p_cnt_q;
      lx_d        = lx_q;
      ly_d        = ly_q;
      a_step      = 1'b0;
      p_step      = 1'b0;
      ang_cur     = player_q ? ang1_q : ang0_q;
      pow_cur     = player_q ? pow1_q : pow0_q;
      ang_new     = ang_cur;
      pow_new     = pow_cur;
      fcnt_inc    = fcnt_q + FW'(1);
      scnt_inc    = scnt_q + SW'(1);

      if (tick_q) begin
         fire_prev_d = key_fire;
         case (state_q)
            S_AIM: begin
               // origin keeps following the tank until the shot leaves AIM
               lx_d = player_q ? p1_x : p0_x;
               ly_d = player_q ? p1_y : p0_y;
               if (!pause) begin
                  if (key_fire && !fire_prev_q) begin
                     state_d  = S_LAUNCH;
                     a_held_d = 1'b0;
                     a_cnt_d  = '0;
                     p_held_d = 1'b0;
                     p_cnt_d  = '0;
                  end else begin
                     // opposing keys together count as released
                     if (key_left ^ key_right) begin
                        if (!a_held_q) begin
                           a_step   = 1'b1;
                           a_held_d = 1'b1;
                           a_cnt_d  = '0;
                        end else if (a_cnt_q == RW'(REPEAT_FRAMES - 1)) begin
                           a_step  = 1'b1;
                           a_cnt_d = '0;
                        end else begin
                           a_cnt_d = a_cnt_q + RW'(1);
                        end
                     end else begin
                        a_held_d = 1'b0;
                        a_cnt_d  = '0;
                     end

                     if (key_up ^ key_down) begin
                        if (!p_held_q) begin
                           p_step   = 1'b1;
                           p_held_d = 1'b1;
                           p_cnt_d  = '0;
                        end else if (p_cnt_q == RW'(REPEAT_FRAMES - 1)) begin
                           p_step  = 1'b1;
                           p_cnt_d = '0;
                        end else begin
                           p_cnt_d = p_cnt_q + RW'(1);
                        end
                     end else begin
                        p_held_d = 1'b0;
                        p_cnt_d  = '0;
                     end

                     if (a_step && key_right && ang_cur != ANGLE_MAX) begin
                        ang_new = ang_cur + 4'd1;
                     end else if (a_step && key_left && ang_cur != 4'd0) begin
                        ang_new = ang_cur - 4'd1;
                     end

                     if (p_step && key_up && pow_cur != POWER_MAX) begin
                        pow_new = pow_cur + 3'd1;
                     end else if (p_step && key_down && pow_cur != 3'd0) begin
                        pow_new = pow_cur - 3'd1;
                     end
                  end
               end
            end
            S_LAUNCH: begin
               state_d = S_FLIGHT;
               fcnt_d  = '0;
               armed_d = 1'b0;
            end
            S_FLIGHT: begin
               if (!pause) begin
                  fcnt_d = fcnt_inc;
                  if (!bomb.bomb_done) begin
                     armed_d = 1'b1;
                  end
                  // armed guards against a done level left over from the last shot
                  if ((armed_q && bomb.bomb_done) ||
                      fcnt_inc == FW'(FLIGHT_TIMEOUT)) begin
                     state_d = S_SETTLE;
                     scnt_d  = '0;
                  end
               end
            end
            S_SETTLE: begin
               if (!pause) begin
                  if (scnt_inc == SW'(SETTLE_FRAMES)) begin
                     state_d = S_SWITCH;
                     scnt_d  = '0;
                  end else begin
                     scnt_d = scnt_inc;
                  end
               end
            end
            S_SWITCH: begin
               player_d = ~player_q;
               tc_d     = tc_q + 8'd1;
               state_d  = S_AIM;
            end
            default: begin
               state_d = S_AIM;
            end
         endcase

         if (player_q) begin
            ang1_d = ang_new;
            pow1_d = pow_new;
         end else begin
            ang0_d = ang_new;
            pow0_d = pow_new;
         end
      end

      launch_d = (state_d == S_LAUNCH);
   end

   assign bomb.launch  = launch_q;
   assign bomb.launchX = lx_q;
   assign bomb.launchY = ly_q;
   assign bomb.angle   = player_q ? ang1_q : ang0_q;
   assign bomb.power   = player_q ? pow1_q : pow0_q;
   assign player       = player_q;
   assign state        = state_q;
   assign turn_count   = tc_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: two full turns plus aim, pause and
// timeout corner cases, checked against hand-computed values.
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic       key_fire = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] p0_x = 10'd100, p0_y = 10'd200, p1_x = 10'd800, p1_y = 10'd300;
  logic       player;
  logic [2:0] state;
  logic [7:0] turn_count;

  int total = 0;
  int passed = 0;
  int failed = 0;

  turn_controller_if bus ();

  turn_controller dut (
    .clk        (clk),
    .reset      (reset),
    .frame_clk  (frame_clk),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_fire   (key_fire),
    .pause      (pause),
    .p0_x       (p0_x),
    .p0_y       (p0_y),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .bomb       (bus),
    .player     (player),
    .state      (state),
    .turn_count (turn_count)
  );

  // clock / frame strobe: one frame = 16 clk, toggled on negedge clk
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (8) @(negedge clk);
      frame_clk = ~frame_clk;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no summary by 1 ms, expected end of sequence");
    $fatal(1, "watchdog expired");
  end

  // launch pulse monitor: width in clk and frame_clk rises inside each pulse
  int lw_cur = 0, lw_last = 0, lr_cur = 0, lr_last = 0, launch_cnt = 0;

  always @(posedge clk) begin
    if (bus.launch) begin
      lw_cur++;
    end else if (lw_cur != 0) begin
      lw_last = lw_cur;
      lr_last = lr_cur;
      lw_cur  = 0;
      lr_cur  = 0;
      launch_cnt++;
    end
  end

  always @(posedge frame_clk) begin
    if (bus.launch) lr_cur++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // returns just after a frame_clk rise; inputs set here feed that frame's tick
  task automatic frame();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) frame();
  endtask

  initial begin
    bus.bomb_done = 1'b1;
    key_fire = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_player", 32'(player), 32'd0);
    check("rst_angle", 32'(bus.angle), 32'd2);
    check("rst_power", 32'(bus.power), 32'd4);
    check("rst_launch", 32'(bus.launch), 32'd0);
    check("rst_turns", 32'(turn_count), 32'd0);
    check("rst_lx", 32'(bus.launchX), 32'd0);
    check("rst_ly", 32'(bus.launchY), 32'd0);

    @(negedge frame_clk);
    #1 reset = 1'b1;
    frame();
    check("pre_tick_lx", 32'(bus.launchX), 32'd0);

    // fire held through reset: no launch for 10 frames
    ticks(10);
    check("held_fire_launch", 32'(bus.launch), 32'd0);
    check("held_fire_state", 32'(state), 32'd0);
    check("first_lx", 32'(bus.launchX), 32'd100);
    check("first_ly", 32'(bus.launchY), 32'd200);

    key_fire = 1'b0;
    ticks(1);
    key_fire = 1'b1;
    ticks(1);
    check("l1_state", 32'(state), 32'd1);
    check("l1_launch", 32'(bus.launch), 32'd1);
    check("l1_angle", 32'(bus.angle), 32'd2);
    check("l1_power", 32'(bus.power), 32'd4);
    check("l1_lx", 32'(bus.launchX), 32'd100);
    check("l1_ly", 32'(bus.launchY), 32'd200);
    key_fire = 1'b0;
    ticks(1);
    check("l1_flight", 32'(state), 32'd2);
    check("l1_launch_low", 32'(bus.launch), 32'd0);
    check("l1_count", 32'(launch_cnt), 32'd1);
    check("l1_width", 32'(lw_last), 32'd16);
    check("l1_rises", 32'(lr_last), 32'd1);

    // bomb in flight for 39 frames, detonates on the 40th
    bus.bomb_done = 1'b0;
    ticks(39);
    check("f1_inflight", 32'(state), 32'd2);
    bus.bomb_done = 1'b1;
    ticks(1);
    check("f1_settle", 32'(state), 32'd3);
    ticks(29);
    check("s1_settle_end", 32'(state), 32'd3);
    ticks(1);
    check("s1_switch", 32'(state), 32'd4);
    ticks(1);
    check("t1_state", 32'(state), 32'd0);
    check("t1_player", 32'(player), 32'd1);
    check("t1_turns", 32'(turn_count), 32'd1);
    check("t1_angle", 32'(bus.angle), 32'd6);
    check("t1_power", 32'(bus.power), 32'd4);
    ticks(1);
    check("t1_lx", 32'(bus.launchX), 32'd800);
    check("t1_ly", 32'(bus.launchY), 32'd300);

    // player 1 aiming: saturation, opposing keys, power auto-repeat
    key_left = 1'b1;
    ticks(100);
    check("left_sat", 32'(bus.angle), 32'd0);
    key_left = 1'b0;
    ticks(1);
    key_right = 1'b1;
    ticks(1);
    check("right_one", 32'(bus.angle), 32'd1);
    key_left = 1'b1;
    ticks(5);
    check("left_right", 32'(bus.angle), 32'd1);
    key_left = 1'b0;
    key_right = 1'b0;
    ticks(1);
    key_up = 1'b1;
    ticks(20);
    check("up_repeat", 32'(bus.power), 32'd7);
    ticks(10);
    check("up_sat", 32'(bus.power), 32'd7);
    key_up = 1'b0;
    ticks(1);
    key_fire = 1'b1;
    key_down = 1'b1;
    ticks(1);
    check("l2_state", 32'(state), 32'd1);
    check("l2_power", 32'(bus.power), 32'd7);
    check("l2_angle", 32'(bus.angle), 32'd1);
    check("l2_lx", 32'(bus.launchX), 32'd800);

    // pause on the LAUNCH tick, bomb never reports in flight
    key_fire = 1'b0;
    key_down = 1'b0;
    pause = 1'b1;
    ticks(1);
    check("l2_flight", 32'(state), 32'd2);
    check("l2_count", 32'(launch_cnt), 32'd2);
    check("l2_width", 32'(lw_last), 32'd16);
    check("l2_rises", 32'(lr_last), 32'd1);
    ticks(2);
    pause = 1'b0;
    ticks(254);
    check("f2_pre_timeout", 32'(state), 32'd2);
    ticks(1);
    check("f2_timeout", 32'(state), 32'd3);

    // pause inside SETTLE holds the counter
    ticks(10);
    pause = 1'b1;
    ticks(50);
    check("s2_paused", 32'(state), 32'd3);
    pause = 1'b0;
    ticks(19);
    check("s2_settle_end", 32'(state), 32'd3);
    ticks(1);
    check("s2_switch", 32'(state), 32'd4);
    ticks(1);
    check("t2_state", 32'(state), 32'd0);
    check("t2_player", 32'(player), 32'd0);
    check("t2_turns", 32'(turn_count), 32'd2);
    check("t2_angle", 32'(bus.angle), 32'd2);
    check("t2_power", 32'(bus.power), 32'd4);
    check("t2_lx_old", 32'(bus.launchX), 32'd800);
    ticks(1);
    check("t2_lx", 32'(bus.launchX), 32'd100);

    // player 0: auto-repeat steps at frames 0, 8, 16
    key_right = 1'b1;
    ticks(20);
    check("right_repeat", 32'(bus.angle), 32'd5);
    key_right = 1'b0;
    ticks(1);

    // pause in AIM freezes aim and swallows the fire edge
    pause = 1'b1;
    key_right = 1'b1;
    ticks(3);
    check("pause_aim", 32'(bus.angle), 32'd5);
    key_right = 1'b0;
    key_fire = 1'b1;
    ticks(1);
    check("pause_fire_state", 32'(state), 32'd0);
    check("pause_fire_launch", 32'(bus.launch), 32'd0);
    pause = 1'b0;
    ticks(1);
    check("fire_edge_lost", 32'(state), 32'd0);
    key_fire = 1'b0;
    ticks(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
